// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer_if
//  Brief    : Sequencer <-> datapath/instruction-memory signal bundle.
//  Revision : 1.0
// ============================================================================
interface cpu_sequencer_if;
    logic [3:0] opcode;
    logic       Z;
    logic       C;
    logic       MemReady;
    logic       Run;
    logic       MemReq;
    logic       LoadIR;
    logic       IncPC;
    logic       SelPC;
    logic       LoadPC;
    logic       LoadReg;
    logic       LoadAcc;
    logic [1:0] SelAcc;
    logic [3:0] SelALU;
    logic       Halted;
    logic [1:0] State;

    modport master (
        input  opcode, Z, C, MemReady, Run,
        output MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
        output SelAcc, SelALU, Halted, State
    );

    modport slave (
        output opcode, Z, C, MemReady, Run,
        input  MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
        input  SelAcc, SelALU, Halted, State
    );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer
//  Brief    : FETCH/DECODE/EXEC/HALT control sequencer for a simple
//             accumulator CPU; strobes decoded from state and opcode.
//  Revision : 1.0
// ============================================================================
module cpu_sequencer (
    input  wire logic        CLK,
    input  wire logic        CLB,
    cpu_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALT   = 2'b11
    } state_t;

    localparam logic [3:0] c_OP_STOP = 4'b1111;

    state_t r_state;
    logic   r_zf;
    logic   r_cf;

    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            r_state <= ST_FETCH;
            r_zf    <= 1'b0;
            r_cf    <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH:  if (bus.MemReady) r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_zf    <= bus.Z;
                    r_cf    <= bus.C;
                    r_state <= ST_EXEC;
                end
                ST_EXEC:   r_state <= (bus.opcode == c_OP_STOP) ? ST_HALT : ST_FETCH;
                ST_HALT:   if (bus.Run) r_state <= ST_FETCH;
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    logic       w_memReq, w_loadIR, w_incPC, w_selPC, w_loadPC, w_loadReg, w_loadAcc;
    logic [1:0] w_selAcc;
    logic [3:0] w_selALU;

    // Everything is gated by CLB so outputs drop in the same instant reset rises.
    always_comb begin
        w_memReq  = 1'b0;
        w_loadIR  = 1'b0;
        w_incPC   = 1'b0;
        w_selPC   = 1'b0;
        w_loadPC  = 1'b0;
        w_loadReg = 1'b0;
        w_loadAcc = 1'b0;
        w_selAcc  = 2'b00;
        w_selALU  = 4'b0000;
        if (!CLB) begin
            case (r_state)
                ST_FETCH: begin
                    w_memReq = 1'b1;
                    w_loadIR = bus.MemReady;
                end
                ST_HALT:  w_incPC = bus.Run;
                ST_EXEC: begin
                    case (bus.opcode)
                        4'b0001: begin w_loadAcc = 1'b1; w_incPC = 1'b1; w_selALU = 4'b1000; end
                        4'b0010: begin w_loadAcc = 1'b1; w_incPC = 1'b1; w_selALU = 4'b1100; end
                        4'b0011: begin w_loadAcc = 1'b1; w_incPC = 1'b1; w_selALU = 4'b0100; end
                        4'b0100: begin w_loadAcc = 1'b1; w_incPC = 1'b1; w_selAcc = 2'b10;   end
                        4'b0101: begin w_loadReg = 1'b1; w_incPC = 1'b1; end
                        4'b0110: begin w_selPC = 1'b1; w_loadPC = r_zf; w_incPC = ~r_zf; end
                        4'b0111: begin w_loadPC = r_zf; w_incPC = ~r_zf; end
                        4'b1000: begin w_selPC = 1'b1; w_loadPC = r_cf; w_incPC = ~r_cf; end
                        4'b1010: begin w_loadPC = r_cf; w_incPC = ~r_cf; end
                        4'b1011: begin w_loadAcc = 1'b1; w_incPC = 1'b1; w_selALU = 4'b0011; end
                        4'b1100: begin w_loadAcc = 1'b1; w_incPC = 1'b1; w_selALU = 4'b0001; end
                        4'b1101: begin w_loadAcc = 1'b1; w_incPC = 1'b1; w_selAcc = 2'b11;   end
                        c_OP_STOP: ;
                        // WAIT plus the undefined 1001/1110 just step the PC.
                        default: w_incPC = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.MemReq  = w_memReq;
    assign bus.LoadIR  = w_loadIR;
    assign bus.IncPC   = w_incPC;
    assign bus.SelPC   = w_selPC;
    assign bus.LoadPC  = w_loadPC;
    assign bus.LoadReg = w_loadReg;
    assign bus.LoadAcc = w_loadAcc;
    assign bus.SelAcc  = w_selAcc;
    assign bus.SelALU  = w_selALU;
    assign bus.Halted  = (r_state == ST_HALT);
    assign bus.State   = r_state;

endmodule
`default_nettype wire
